// File: rtl/logic_unit_arbiter_pkg.sv
//============================================================================
// Module  : logic_unit_arbiter_pkg
// Purpose : Shared definitions for the logic-unit arbiter: opcode encodings,
//           FSM state encodings and a helper for the requester-ID width.
// Ports   : none (package)
// Rev     : 1.0 - initial release
//============================================================================
`default_nettype none

package logic_unit_arbiter_pkg;

   // Opcodes understood by the shared logic unit
   localparam logic [1:0] OP_NAND = 2'b00;
   localparam logic [1:0] OP_NOR  = 2'b01;
   localparam logic [1:0] OP_XNOR = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   // Arbiter FSM states
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RESP = 1'b1;

   // Width of a requester index; never narrower than one bit
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : logic_unit_arbiter_pkg

`default_nettype wire

// File: rtl/logic_unit_arbiter_logic_unit.sv
//============================================================================
// Module  : logic_unit
// Purpose : Shared combinational W-bit NAND / NOR / XNOR datapath.
//           The reserved opcode yields zero data and raises err.
// Ports   : a, b  in  W   operands
//           op    in  2   opcode
//           y     out W   result
//           err   out 1   reserved opcode seen
// Rev     : 1.0 - initial release
//============================================================================
`default_nettype none

module logic_unit
   import logic_unit_arbiter_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [1:0]   op,
   output logic [W-1:0] y,
   output logic         err
);

   always_comb begin
      y   = '0;
      err = 1'b0;
      case (op)
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
         default: err = 1'b1;
      endcase
   end

endmodule : logic_unit

`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
//============================================================================
// Module  : logic_unit_arbiter
// Purpose : Round-robin arbiter sharing one logic unit among NREQ requesters.
//           A winner is accepted in IDLE, its result is registered, and the
//           result is held in RESP until the consumer takes it.
// Ports   : clk        in  1          rising-edge clock
//           rst_n      in  1          asynchronous active-low reset
//           req_valid  in  NREQ       per-requester valid
//           req_ready  out NREQ       one-hot accept (zero when none)
//           req_a/b    in  NREQ*W     operands, requester i at [i*W +: W]
//           req_op     in  NREQ*2     opcodes, requester i at [i*2 +: 2]
//           rsp_valid  out 1          result valid
//           rsp_ready  in  1          consumer accept
//           rsp_data   out W          registered result
//           rsp_id     out ID_W       served requester index
//           rsp_err    out 1          reserved opcode issued
//           ops_done   out CNT_W      completed responses, wrapping
// Rev     : 1.0 - initial release
//============================================================================
`default_nettype none

module logic_unit_arbiter
   import logic_unit_arbiter_pkg::*;
#(
   parameter  int NREQ  = 4,
   parameter  int W     = 8,
   parameter  int CNT_W = 16,
   localparam int ID_W  = id_width(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ*2-1:0] req_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [W-1:0]      rsp_data,
   output logic [ID_W-1:0]   rsp_id,
   output logic              rsp_err,
   output logic [CNT_W-1:0]  ops_done
);

   logic [0:0]      state;
   logic [ID_W-1:0] rr_ptr;

   logic            win_found;
   logic [ID_W-1:0] win_idx;
   logic [ID_W:0]   idx_ext;
   logic [ID_W-1:0] ptr_next;

   logic [W-1:0]    a_sel;
   logic [W-1:0]    b_sel;
   logic [1:0]      op_sel;
   logic [W-1:0]    lu_y;
   logic            lu_err;

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   // One extra bit keeps rr_ptr + k from overflowing before the modulo.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx_ext   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_ext = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (idx_ext >= (ID_W+1)'(NREQ))
            idx_ext = idx_ext - (ID_W+1)'(NREQ);
         if (!win_found && req_valid[idx_ext[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = idx_ext[ID_W-1:0];
         end
      end
   end

   assign ptr_next = (win_idx == ID_W'(NREQ-1)) ? '0 : win_idx + ID_W'(1);

   // Operand mux feeding the shared datapath
   always_comb begin
      a_sel  = '0;
      b_sel  = '0;
      op_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == ID_W'(i)) begin
            a_sel  = req_a[i*W +: W];
            b_sel  = req_b[i*W +: W];
            op_sel = req_op[i*2 +: 2];
         end
      end
   end

   logic_unit #(.W(W)) u_logic_unit (
      .a   (a_sel),
      .b   (b_sel),
      .op  (op_sel),
      .y   (lu_y),
      .err (lu_err)
   );

   // Grant is combinational; rst_n gating keeps it low throughout reset
   // even though the FSM already sits in IDLE.
   always_comb begin
      req_ready = '0;
      if (rst_n && (state == S_IDLE) && win_found)
         req_ready[win_idx] = 1'b1;
   end

   // Derived from state so an asynchronous reset drops it immediately
   assign rsp_valid = (state == S_RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
         rsp_err  <= 1'b0;
         ops_done <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  rsp_data <= lu_y;
                  rsp_id   <= win_idx;
                  rsp_err  <= lu_err;
                  rr_ptr   <= ptr_next;
                  state    <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  ops_done <= ops_done + CNT_W'(1);
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule : logic_unit_arbiter

`default_nettype wire
